// File: rtl/uart_seq_checker.sv
// uart_seq_checker: checks received UART words against an incrementing or
// LFSR sequence, keeps saturating statistics and echoes words through a FIFO.
module uart_seq_checker #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       CNT_W      = 16,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] POLY       = DATA_W'(8'hB8),
  parameter bit                RESYNC     = 1'b0
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic              clear,
  input  logic              mode,
  input  logic              echo_en,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  total_cnt,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              locked,
  output logic              overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic {CHK_UNLOCKED, CHK_LOCKED} chk_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SENT, TX_BUSY} tx_state_t;

  // Sequence successor: increment or Fibonacci-style LFSR shift (0 stays 0).
  function automatic logic [DATA_W-1:0] f_next(input logic [DATA_W-1:0] x,
                                               input logic              m);
    if (m) f_next = {x[DATA_W-2:0], ^(x & POLY)};
    else   f_next = x + DATA_W'(1);
  endfunction

  chk_state_t        r_chk_state, w_chk_next;
  tx_state_t         r_tx_state, w_tx_next;
  logic [DATA_W-1:0] r_expected, w_expected_nxt;
  logic              w_good_inc, w_err_inc;
  logic [CNT_W-1:0]  r_total_cnt, r_good_cnt, r_err_cnt, r_drop_cnt;
  logic              r_overflow;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [PW-1:0]     w_count;
  logic              w_empty, w_full;
  logic              w_push_req, w_push, w_pop, w_drop;
  logic [DATA_W-1:0] w_head;

  logic              r_sent_cnt, w_sent_cnt_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;

  // ---------------- checker ----------------

  // Checker state register.
  always_ff @(posedge SYSCLK or negedge SYSRST) begin
    if (!SYSRST) r_chk_state <= CHK_UNLOCKED;
    else         r_chk_state <= w_chk_next;
  end

  // Checker next state: first accepted word locks, clear unlocks.
  always_comb begin
    w_chk_next = r_chk_state;
    if (clear)         w_chk_next = CHK_UNLOCKED;
    else if (rx_valid) w_chk_next = CHK_LOCKED;
  end

  // Checker outputs: prediction update and good/error classification.
  always_comb begin
    w_expected_nxt = r_expected;
    w_good_inc     = 1'b0;
    w_err_inc      = 1'b0;
    if (clear) begin
      w_expected_nxt = '0;
    end else if (rx_valid) begin
      if (r_chk_state == CHK_UNLOCKED) begin
        w_expected_nxt = f_next(rx_data, mode);
      end else if (rx_data == r_expected) begin
        w_good_inc     = 1'b1;
        w_expected_nxt = f_next(r_expected, mode);
      end else begin
        w_err_inc      = 1'b1;
        w_expected_nxt = RESYNC ? f_next(rx_data, mode) : f_next(r_expected, mode);
      end
    end
  end

  // Predicted next word.
  always_ff @(posedge SYSCLK or negedge SYSRST) begin
    if (!SYSRST) r_expected <= '0;
    else         r_expected <= w_expected_nxt;
  end

  // Saturating statistics counters and sticky overflow flag.
  always_ff @(posedge SYSCLK or negedge SYSRST) begin
    if (!SYSRST) begin
      r_total_cnt <= '0;
      r_good_cnt  <= '0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_total_cnt <= '0;
      r_good_cnt  <= '0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (rx_valid && (r_total_cnt != '1)) r_total_cnt <= r_total_cnt + CNT_W'(1);
      if (w_good_inc && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + CNT_W'(1);
      if (w_err_inc && (r_err_cnt != '1))   r_err_cnt  <= r_err_cnt + CNT_W'(1);
      if (w_drop && (r_drop_cnt != '1))     r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      if (w_drop)                           r_overflow <= 1'b1;
    end
  end

  // ---------------- echo FIFO ----------------

  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == PW'(FIFO_DEPTH));
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_push_req = rx_valid & echo_en & ~clear;
  // Pop only from IDLE; clear flushes so flushed data is never strobed.
  assign w_pop      = (r_tx_state == TX_IDLE) & ~w_empty & ~tx_busy & ~clear;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge SYSCLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= rx_data;
  end

  // FIFO pointers with wrap bit.
  always_ff @(posedge SYSCLK or negedge SYSRST) begin
    if (!SYSRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // ---------------- transmit handshake ----------------

  // TX state register plus SENT dwell counter and registered strobe/data.
  always_ff @(posedge SYSCLK or negedge SYSRST) begin
    if (!SYSRST) begin
      r_tx_state <= TX_IDLE;
      r_sent_cnt <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_sent_cnt <= w_sent_cnt_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  // TX next state: SENT waits for busy or times out after two cycles.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (w_pop) w_tx_next = TX_SENT;
      TX_SENT: if (tx_busy || r_sent_cnt) w_tx_next = TX_BUSY;
      TX_BUSY: if (!tx_busy) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: strobe on pop, hold data between strobes.
  always_comb begin
    w_tx_valid_nxt = w_pop;
    w_tx_data_nxt  = w_pop ? w_head : r_tx_data;
    w_sent_cnt_nxt = 1'b0;
    if (r_tx_state == TX_SENT) w_sent_cnt_nxt = 1'b1;
  end

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign total_cnt = r_total_cnt;
  assign good_cnt  = r_good_cnt;
  assign err_cnt   = r_err_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;
  assign locked    = (r_chk_state == CHK_LOCKED);

endmodule

// File: tb/tb_uart_seq_checker.sv
// Scoreboard bench for uart_seq_checker: directed vectors, echo expectations
// queued at issue time and checked by an independent monitor.
module tb_uart_seq_checker;

  logic       SYSCLK = 1'b0;
  logic       SYSRST;
  logic       clear, mode, echo_en, rx_valid, tx_busy;
  logic [7:0] rx_data;

  logic        tx_valid, locked, overflow;
  logic [7:0]  tx_data;
  logic [15:0] total_cnt, good_cnt, err_cnt, drop_cnt;

  logic        rs_tx_valid, rs_locked, rs_overflow;
  logic [7:0]  rs_tx_data;
  logic [15:0] rs_total, rs_good, rs_err, rs_drop;

  logic        c4_tx_valid, c4_locked, c4_overflow;
  logic [7:0]  c4_tx_data;
  logic [3:0]  c4_total, c4_good, c4_err, c4_drop;

  int         errors = 0;
  int         checks = 0;
  int         n_strobe = 0;
  bit         prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  int         busy_len = 10;
  int         busy_cnt = 0;
  bit         busy_kill = 1'b0;
  int         base;

  always #5 SYSCLK = ~SYSCLK;

  uart_seq_checker u_main (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .clear(clear), .mode(mode), .echo_en(echo_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(tx_valid), .tx_data(tx_data), .total_cnt(total_cnt), .good_cnt(good_cnt),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt), .locked(locked), .overflow(overflow));

  uart_seq_checker #(.RESYNC(1'b1)) u_rs (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .clear(clear), .mode(mode), .echo_en(echo_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(rs_tx_valid), .tx_data(rs_tx_data), .total_cnt(rs_total), .good_cnt(rs_good),
    .err_cnt(rs_err), .drop_cnt(rs_drop), .locked(rs_locked), .overflow(rs_overflow));

  uart_seq_checker #(.CNT_W(4)) u_c4 (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .clear(clear), .mode(mode), .echo_en(echo_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(c4_tx_valid), .tx_data(c4_tx_data), .total_cnt(c4_total), .good_cnt(c4_good),
    .err_cnt(c4_err), .drop_cnt(c4_drop), .locked(c4_locked), .overflow(c4_overflow));

  // UART core model: busy for busy_len cycles after each strobe.
  always @(negedge SYSCLK) begin
    if (!SYSRST || busy_kill) busy_cnt = 0;
    else if (tx_valid)        busy_cnt = busy_len;
    else if (busy_cnt != 0)   busy_cnt = busy_cnt - 1;
    tx_busy = (busy_cnt != 0);
  end

  // Monitor: every strobe must match the oldest expected echo and last one cycle.
  always @(negedge SYSCLK) begin
    if (SYSRST && tx_valid) begin
      n_strobe = n_strobe + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_strobe: got tx_data=%h, required no strobe", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors = errors + 1;
          $display("FAIL echo_data: got %h, required %h", tx_data, e);
        end
      end
      checks = checks + 1;
      if (prev_valid) begin
        errors = errors + 1;
        $display("FAIL strobe_width: tx_valid high on consecutive cycles, required 1-cycle pulse");
      end
    end
    prev_valid = tx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge SYSCLK);
  endtask

  task automatic send(input logic [7:0] d, input bit exp_echo);
    rx_data  = d;
    rx_valid = 1'b1;
    if (exp_echo) exp_q.push_back(d);
    @(negedge SYSCLK);
    rx_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge SYSCLK);
    clear = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge SYSCLK);
    end
    chk("echo_drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    SYSRST = 1'b0; clear = 1'b0; mode = 1'b0; echo_en = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    idle(3);
    SYSRST = 1'b1;
    idle(2);

    // Reset state
    chk("rst_total", 32'(total_cnt), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Incrementing run with echo, busy 10 cycles per strobe
    busy_len = 10;
    for (int d = 5; d <= 12; d++) begin
      send(8'(d), 1'b1);
      idle(15);
    end
    wait_drain(100);
    idle(15);
    chk("inc_total", 32'(total_cnt), 8);
    chk("inc_good", 32'(good_cnt), 7);
    chk("inc_err", 32'(err_cnt), 0);
    chk("inc_locked", 32'(locked), 1);
    chk("inc_drop", 32'(drop_cnt), 0);
    chk("inc_strobes", 32'(n_strobe), 8);
    chk("inc_rs_good", 32'(rs_good), 7);

    // Mismatch handling with and without resync
    do_clear();
    echo_en = 1'b0;
    send(8'h00, 0); send(8'h01, 0); send(8'h07, 0); send(8'h08, 0);
    idle(1);
    chk("mis_total", 32'(total_cnt), 4);
    chk("mis_good", 32'(good_cnt), 1);
    chk("mis_err", 32'(err_cnt), 2);
    chk("mis_rs_good", 32'(rs_good), 2);
    chk("mis_rs_err", 32'(rs_err), 1);

    // LFSR sequence
    mode = 1'b1;
    do_clear();
    send(8'h01, 0); send(8'h02, 0); send(8'h04, 0); send(8'h08, 0); send(8'h11, 0);
    idle(1);
    chk("lfsr_good", 32'(good_cnt), 4);
    chk("lfsr_err", 32'(err_cnt), 0);
    chk("lfsr_locked", 32'(locked), 1);
    mode = 1'b0;
    do_clear();
    chk("clr_overflow_pre", 32'(overflow), 0);

    // Echo overflow: busy held after the first strobe, 6 back-to-back words
    echo_en  = 1'b1;
    busy_len = 100000;
    base = n_strobe;
    for (int k = 0; k < 6; k++) send(8'(8'h20 + k), k < 5);
    idle(2);
    chk("ovf_drop", 32'(drop_cnt), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_first_strobes", 32'(n_strobe - base), 1);
    busy_len  = 3;
    busy_kill = 1'b1;
    idle(2);
    busy_kill = 1'b0;
    wait_drain(200);
    idle(10);
    chk("ovf_total_strobes", 32'(n_strobe - base), 5);
    chk("ovf_drop_after", 32'(drop_cnt), 1);

    // Counter saturation at CNT_W=4, then clear colliding with rx_valid
    do_clear();
    chk("clr_overflow", 32'(overflow), 0);
    echo_en = 1'b0;
    for (int k = 0; k < 20; k++) send(8'(8'h40 + k), 0);
    idle(1);
    chk("sat_c4_total", 32'(c4_total), 15);
    chk("sat_c4_good", 32'(c4_good), 15);
    chk("sat_main_total", 32'(total_cnt), 20);
    chk("sat_main_good", 32'(good_cnt), 19);
    echo_en  = 1'b1;
    base     = n_strobe;
    clear    = 1'b1;
    rx_data  = 8'h54;
    rx_valid = 1'b1;
    @(negedge SYSCLK);
    clear    = 1'b0;
    rx_valid = 1'b0;
    chk("clr_total", 32'(total_cnt), 0);
    chk("clr_good", 32'(good_cnt), 0);
    chk("clr_c4_total", 32'(c4_total), 0);
    chk("clr_locked", 32'(locked), 0);
    idle(8);
    chk("clr_no_echo", 32'(n_strobe - base), 0);

    // Asynchronous reset mid-BUSY with two words queued
    busy_len = 20;
    send(8'h60, 1); send(8'h61, 0); send(8'h62, 0);
    idle(3);
    chk("pre_rst_total", 32'(total_cnt), 3);
    chk("pre_rst_tx_data", 32'(tx_data), 32'h60);
    SYSRST = 1'b0;
    #1;
    chk("arst_tx_data", 32'(tx_data), 0);
    chk("arst_tx_valid", 32'(tx_valid), 0);
    chk("arst_total", 32'(total_cnt), 0);
    chk("arst_locked", 32'(locked), 0);
    @(negedge SYSCLK);
    SYSRST = 1'b1;
    base = n_strobe;
    idle(30);
    chk("post_rst_no_strobe", 32'(n_strobe - base), 0);
    chk("post_rst_queue", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
